inst_fetch_bridge: RTL and testbench

Instruction-fetch bridge between the `openmips` core's ROM port and a multi-cycle, handshaked instruction memory bus. It caches the most recently fetched word and serves hits in the same cycle. On a miss it runs a bus request/acknowledge transaction and raises a stall request, which `ctrl` merges with `stallreq_from_id` and `stallreq_from_ex` to freeze PC and IF/ID. A timeout watchdog converts a hung bus into a NOP plus an error pulse.

---
 rtl/inst_fetch_bridge_pkg.sv | 18 +
 rtl/inst_fetch_bridge.sv | 118 +++++++++++
 tb/tb_inst_fetch_bridge.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge: bus widths, fixed words and
// the fetch FSM state codes.
package inst_fetch_bridge_pkg;

    localparam int unsigned RegBus         = 32;
    localparam int unsigned InstAddrBus    = 32;
    localparam int unsigned IfTimeoutWidth = 8;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;
    localparam logic [RegBus-1:0] NopInst  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IfIdle = 2'b00,
        IfReq  = 2'b01,
        IfWait = 2'b10
    } if_state_e;

endpackage

// File: rtl/inst_fetch_bridge.sv
// Single-entry fetch buffer between the core ROM port and a handshaked instruction bus.
// Hits are served combinationally; misses stall the core while a bus read runs.
module inst_fetch_bridge
    import inst_fetch_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [InstAddrBus-1:0] rom_addr_i,
    output logic [RegBus-1:0]      rom_data_o,
    output logic                   stallreq_o,
    input  logic                   flush_i,
    output logic                   bus_req_o,
    output logic [InstAddrBus-1:0] bus_addr_o,
    input  logic                   bus_ack_i,
    input  logic [RegBus-1:0]      bus_rdata_i,
    output logic                   err_o
);

    localparam logic [IfTimeoutWidth-1:0] TimeoutCnt = IfTimeoutWidth'(TIMEOUT);

    if_state_e                   state_q, state_d;
    logic                        buf_valid_q, buf_valid_d;
    logic [InstAddrBus-3:0]      buf_addr_q, buf_addr_d;
    logic [RegBus-1:0]           buf_data_q, buf_data_d;
    logic [InstAddrBus-3:0]      req_addr_q, req_addr_d;
    logic [IfTimeoutWidth-1:0]   cnt_q, cnt_d;
    logic                        drop_q, drop_d;
    logic                        err_q, err_d;
    logic                        hit;

    // Byte offset within the word is irrelevant to a word fetch.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^rom_addr_i[1:0];

    assign hit        = rom_ce_i && buf_valid_q && (buf_addr_q == rom_addr_i[InstAddrBus-1:2]);
    assign rom_data_o = hit ? buf_data_q : ZeroWord;
    assign stallreq_o = rom_ce_i && !hit;
    assign bus_req_o  = (state_q == IfReq) || (state_q == IfWait);
    assign bus_addr_o = bus_req_o ? {req_addr_q, 2'b00} : '0;
    assign err_o      = err_q;

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        req_addr_d  = req_addr_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        err_d       = 1'b0;

        unique case (state_q)
            IfIdle: begin
                if (rom_ce_i && !hit) begin
                    req_addr_d = rom_addr_i[InstAddrBus-1:2];
                    drop_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = IfReq;
                end
            end
            IfReq: begin
                if (flush_i) drop_d = 1'b1;
                // First WAIT cycle carries count 1, so the timeout fires on the
                // TIMEOUT-th WAIT cycle.
                cnt_d   = IfTimeoutWidth'(1);
                state_d = IfWait;
            end
            IfWait: begin
                if (flush_i) drop_d = 1'b1;
                if (bus_ack_i) begin
                    if (!(drop_q || flush_i)) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q;
                        buf_data_d  = bus_rdata_i;
                    end
                    state_d = IfIdle;
                end else if (cnt_q == TimeoutCnt) begin
                    if (!(drop_q || flush_i)) begin
                        buf_valid_d = 1'b1;
                        buf_addr_d  = req_addr_q;
                        buf_data_d  = NopInst;
                    end
                    err_d   = 1'b1;
                    state_d = IfIdle;
                end else begin
                    cnt_d = cnt_q + IfTimeoutWidth'(1);
                end
            end
            default: state_d = IfIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IfIdle;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            req_addr_q  <= '0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            req_addr_q  <= req_addr_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge with a small instruction-bus responder and a
// scoreboard queue of expected fetch results.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;
    logic        stallreq_o;
    logic        flush_i;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        err_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];

    inst_fetch_bridge #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .rom_ce_i   (rom_ce_i),
        .rom_addr_i (rom_addr_i),
        .rom_data_o (rom_data_o),
        .stallreq_o (stallreq_o),
        .flush_i    (flush_i),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch one address until the stall clears; the responder acks on the bus-request
    // cycle whose index (REQ = 1) equals ack_at + 1, i.e. WAIT cycle ack_at. ack_at = 0: never.
    task automatic run_fetch(input string tag, input logic [31:0] addr, input int ack_at,
                             input logic [31:0] rdata, input logic [31:0] exp,
                             output int stalls, output int reqs, output int errs);
        logic [31:0] exp_word;
        logic [31:0] got;
        bit          done;
        stalls = 0;
        reqs   = 0;
        errs   = 0;
        done   = 1'b0;
        got    = 32'hxxxx_xxxx;
        sb_q.push_back(exp);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            rom_ce_i    = 1'b1;
            rom_addr_i  = addr;
            flush_i     = 1'b0;
            bus_ack_i   = bus_req_o && (ack_at > 0) && (reqs == ack_at);
            bus_rdata_i = bus_ack_i ? rdata : $urandom;
            #1;
            if (bus_req_o) reqs++;
            if (err_o) errs++;
            if (!stallreq_o) begin
                got  = rom_data_o;
                done = 1'b1;
                break;
            end
            stalls++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        exp_word = sb_q.pop_front();
        chk({tag, "_data"}, got, exp_word);
    endtask

    int st, rq, er;

    initial begin
        rst_n       = 1'b0;
        rom_ce_i    = 1'b0;
        rom_addr_i  = 32'h0;
        flush_i     = 1'b0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'h0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        chk("rst_data", rom_data_o, 32'h0);
        chk("rst_req", {31'd0, bus_req_o}, 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss with ack on WAIT cycle 3
        run_fetch("miss0", 32'h0, 3, 32'h3401_1100, 32'h3401_1100, st, rq, er);
        chk("miss0_stall", st, 5);
        chk("miss0_reqs", rq, 4);
        chk("miss0_err", er, 0);

        // Hits on the same word, low address bits ignored
        run_fetch("hit0", 32'h0, 0, 32'h0, 32'h3401_1100, st, rq, er);
        chk("hit0_stall", st, 0);
        chk("hit0_reqs", rq, 0);
        run_fetch("hit2", 32'h2, 0, 32'h0, 32'h3401_1100, st, rq, er);
        chk("hit2_stall", st, 0);

        // Timeout: no ack ever, NOP captured and one error pulse
        run_fetch("tmo", 32'h4, 0, 32'h0, 32'h0, st, rq, er);
        chk("tmo_reqs", rq, 9);
        chk("tmo_err", er, 1);
        chk("tmo_stall", st, 10);
        @(negedge clk);
        #1;
        chk("tmo_err_once", {31'd0, err_o}, 32'd0);

        // Flush during WAIT: the returning word for 0x8 must be discarded
        @(negedge clk);
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h8;
        #1;
        chk("fl_miss", {31'd0, stallreq_o}, 32'd1);
        @(negedge clk);
        #1;
        chk("fl_req_addr", bus_addr_o, 32'h8);
        @(negedge clk);
        flush_i    = 1'b1;
        rom_addr_i = 32'h20;
        #1;
        chk("fl_wait_req", {31'd0, bus_req_o}, 32'd1);
        @(negedge clk);
        flush_i     = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack_i  = 1'b0;
        rom_addr_i = 32'h4;
        #1;
        chk("fl_old_hit", {31'd0, stallreq_o}, 32'd0);
        chk("fl_old_data", rom_data_o, 32'h0);
        rom_addr_i = 32'h8;
        #1;
        chk("fl_dropped", {31'd0, stallreq_o}, 32'd1);
        rom_addr_i = 32'h20;
        #1;
        chk("fl_idle_req", {31'd0, bus_req_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("fl_new_req", {31'd0, bus_req_o}, 32'd1);
        chk("fl_new_addr", bus_addr_o, 32'h20);
        sb_q.push_back(32'h2400_0020);
        @(negedge clk);
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h2400_0020;
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        chk("fl_new_stall", {31'd0, stallreq_o}, 32'd0);
        chk("fl_new_data", rom_data_o, sb_q.pop_front());

        // Ack on the very cycle the counter reaches TIMEOUT
        run_fetch("race", 32'hC, 8, 32'h2108_0001, 32'h2108_0001, st, rq, er);
        chk("race_reqs", rq, 9);
        chk("race_err", er, 0);
        @(negedge clk);
        #1;
        chk("race_err_after", {31'd0, err_o}, 32'd0);

        // Reset during WAIT
        @(negedge clk);
        rom_addr_i = 32'h40;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rw_req_before", {31'd0, bus_req_o}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_req_async", {31'd0, bus_req_o}, 32'd0);
        chk("rw_addr_async", bus_addr_o, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        rom_ce_i  = 1'b0;
        bus_ack_i = 1'b1;
        bus_rdata_i = 32'hBAD0_0BAD;
        @(negedge clk);
        bus_ack_i = 1'b0;
        #1;
        chk("rw_late_ack_req", {31'd0, bus_req_o}, 32'd0);
        chk("rw_late_ack_err", {31'd0, err_o}, 32'd0);
        rom_ce_i   = 1'b1;
        rom_addr_i = 32'h40;
        #1;
        chk("rw_late_ack_miss", {31'd0, stallreq_o}, 32'd1);
        rom_ce_i = 1'b0;
        #1;
        chk("rw_ce_low_stall", {31'd0, stallreq_o}, 32'd0);
        run_fetch("rw_refetch", 32'hC, 2, 32'h2108_0002, 32'h2108_0002, st, rq, er);
        chk("rw_refetch_stall", st, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
